jtframe_ioctl_prog: RTL
=======================

Name: jtframe_ioctl_prog

Overview:
- Download stage between the ioctl byte stream from the MiST SPI firmware and the SDRAM controller's prog_* write port.
- Strips an optional file header and maps each byte to an SDRAM bank, word address and byte lane.
- Diverts PROM-region bytes to a direct strobe, and buffers bytes so the SDRAM write latency never stalls ioctl.
- Drives dwnld_busy to the game core.

Parameters:
- SDRAMW, 22: SDRAM word-address width.
- HEADER, 0: leading file bytes discarded (0..255).
- BA1_START, 25'h1FF_FFFF: first post-header byte address of bank 1.
- BA2_START, 25'h1FF_FFFF: first post-header byte address of bank 2.
- BA3_START, 25'h1FF_FFFF: first post-header byte address of bank 3.
- PROM_START, 25'h1FF_FFFF: first post-header byte address routed to the prom_* strobe.
- SWAB, 0: 1 swaps the byte lane (odd byte to low lane).
- FIFO_AW, 2: FIFO depth is 2^FIFO_AW entries.

Ports:
- clk, in, 1: system clock (clk_rom domain).
- rst_n, in, 1: reset, asynchronous, active-low.
- downloading, in, 1: ioctl download window.
- ioctl_addr, in, 25: byte address.
- ioctl_dout, in, 8: byte data.
- ioctl_wr, in, 1: one-cycle byte strobe.
- prog_addr, out, SDRAMW: word address within the bank.
- prog_data, out, 16: byte duplicated on both lanes.
- prog_mask, out, 2: active-low lane enable; bit0 = low lane.
- prog_ba, out, 2: bank.
- prog_we, out, 1: write request.
- prog_ack, in, 1: controller accepted the request.
- prog_rdy, in, 1: write completed.
- prom_we, out, 1: one-cycle PROM byte strobe.
- prom_addr, out, 25: PROM byte offset (eff - PROM_START).
- prom_data, out, 8: PROM byte.
- dwnld_busy, out, 1: downloading OR FIFO non-empty OR write outstanding.
- overflow, out, 1: sticky, a byte was dropped.

Behaviour:
- Reset: every output 0; FIFO empty; FSM in IDLE. Reset mid-write abandons the write, no replay.
- Address decode, combinational on ioctl_wr. eff = ioctl_addr - HEADER, 25-bit unsigned.
  - ioctl_addr < HEADER: byte ignored.
  - eff >= PROM_START: prom path.
  - Otherwise bank = highest k with eff >= BAk_START (k = 3, 2, 1), else 0.
  - off = eff - BAk_START (BA0 = 0). Word address = off[SDRAMW:1], truncated to SDRAMW.
  - lane = off[0] ^ SWAB. lane 0: mask 2'b10. lane 1: mask 2'b01.
- PROM path: registered; prom_we pulses exactly one cycle, one cycle after ioctl_wr, with prom_addr and prom_data valid. It bypasses the FIFO and the SDRAM queue. PROM and SDRAM ordering is not preserved.
- FIFO:
  - Entry = {ba, word addr, mask, byte}.
  - Push on an SDRAM-path ioctl_wr. If full, the byte is dropped and overflow is set.
  - Simultaneous push and pop when full is accepted (pop frees the slot in the same cycle).
  - overflow clears only on reset or on a rising edge of downloading.
- FSM, one write outstanding at a time:
  - IDLE: FIFO non-empty -> load outputs from head, pop, prog_we=1 -> REQ.
  - REQ: hold prog_addr/data/mask/ba stable. On prog_ack, prog_we=0 the next cycle -> WAIT. If prog_ack and prog_rdy arrive together -> IDLE directly.
  - WAIT: on prog_rdy -> IDLE.
  - Minimum latency from ioctl_wr on an empty FIFO to prog_we high is 2 cycles (push, then issue).
  - prog_rdy seen in IDLE or REQ without a prior ack is ignored.
- Downloading falls with work pending: the FIFO drains normally and dwnld_busy stays high until the last prog_rdy, then drops the next cycle.
- ioctl_wr while downloading=0 is still processed; downloading only affects dwnld_busy and the overflow clear.
- prog_data, prog_mask and prog_ba hold their last values after the write. prog_addr is not forced to 0.

Decomposition:
- Package jtframe_prog_pkg holds:
  - typedef prog_entry_t {ba[1:0], addr[SDRAMW-1:0], mask[1:0], data[7:0]};
  - FSM enum {IDLE, REQ, WAIT};
  - localparam mask constants LANE0_MASK = 2'b10 and LANE1_MASK = 2'b01.
- One sub-module, jtframe_prog_fifo: synchronous FIFO with push/pop, full/empty and async active-low reset.
- Decode and FSM stay in the top.

Test Plan:
- HEADER=4, BA1_START=0x100: bytes at ioctl_addr 0..5 = 11,22,33,44,A5,5A.
  - Bytes 0..3 produce no prog_we.
  - Then writes (ba0, addr 0, data A5A5, mask 10) and (ba0, addr 0, data 5A5A, mask 01).
- ioctl_addr = 4+0x103 (BA1_START=0x100), byte 77 -> prog_ba=1, prog_addr=1, mask=01, data=7777. With SWAB=1 -> mask=10.
- PROM_START=0x8000, eff=0x8010, byte 3C -> prom_we high 1 cycle, prom_addr=0x10, prom_data=3C; no prog_we.
- FIFO_AW=2, prog_ack withheld, 6 back-to-back ioctl_wr -> first issued, next 4 buffered, 6th dropped, overflow=1. Then 5 writes complete in order; overflow clears on the next downloading rise.
- prog_ack and prog_rdy in the same cycle -> FSM returns to IDLE; next entry issues the following cycle.
- Download ends with 3 pending writes -> dwnld_busy stays 1 until the 3rd prog_rdy, 0 one cycle later. rst_n low mid-REQ -> prog_we=0 immediately, FIFO empty.

Source files
------------

// File: rtl/jtframe_prog_pkg.sv
// Shared types for the ioctl-to-SDRAM download stage: queued write entry,
// write FSM states and byte-lane mask encodings.
package jtframe_prog_pkg;

    // Widest word address a 25-bit byte offset can produce.
    localparam int unsigned PROG_AW = 24;

    localparam logic [1:0] LANE0_MASK = 2'b10;
    localparam logic [1:0] LANE1_MASK = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } prog_state_e;

    typedef struct packed {
        logic [1:0]         ba;
        logic [PROG_AW-1:0] addr;
        logic [1:0]         mask;
        logic [7:0]         data;
    } prog_entry_t;

    function automatic logic [1:0] lane_mask(input logic lane);
        return lane ? LANE1_MASK : LANE0_MASK;
    endfunction

endpackage

// File: rtl/jtframe_prog_fifo.sv
// Show-ahead synchronous FIFO; a push while full is accepted only when a pop
// frees the slot in the same cycle.
module jtframe_prog_fifo #(
    parameter int unsigned W  = 8,
    parameter int unsigned AW = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int unsigned DEPTH   = 1 << AW;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] PTR_CAP = {1'b1, {AW{1'b0}}};

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = ((wr_ptr_q - rd_ptr_q) == PTR_CAP);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/jtframe_ioctl_prog.sv
// ioctl byte stream to SDRAM prog_* port: header strip, bank/lane decode,
// PROM strobe bypass and a FIFO so SDRAM latency never back-pressures ioctl.
module jtframe_ioctl_prog
    import jtframe_prog_pkg::*;
#(
    parameter int unsigned SDRAMW     = 22,
    parameter int unsigned HEADER     = 0,
    parameter logic [24:0] BA1_START  = 25'h1FF_FFFF,
    parameter logic [24:0] BA2_START  = 25'h1FF_FFFF,
    parameter logic [24:0] BA3_START  = 25'h1FF_FFFF,
    parameter logic [24:0] PROM_START = 25'h1FF_FFFF,
    parameter bit          SWAB       = 1'b0,
    parameter int unsigned FIFO_AW    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              downloading,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              ioctl_wr,
    output logic [SDRAMW-1:0] prog_addr,
    output logic [15:0]       prog_data,
    output logic [1:0]        prog_mask,
    output logic [1:0]        prog_ba,
    output logic              prog_we,
    input  logic              prog_ack,
    input  logic              prog_rdy,
    output logic              prom_we,
    output logic [24:0]       prom_addr,
    output logic [7:0]        prom_data,
    output logic              dwnld_busy,
    output logic              overflow
);

    localparam logic [24:0] HDR = 25'(HEADER);

    logic [24:0] eff, bank_base, off;
    logic [1:0]  bank;
    logic        hdr_skip, is_prom;
    logic        sdram_push, prom_hit;
    prog_entry_t new_entry, head;
    logic [$bits(prog_entry_t)-1:0] fifo_dout;
    logic        fifo_full, fifo_empty;

    always_comb begin
        eff      = ioctl_addr - HDR;
        hdr_skip = (ioctl_addr < HDR);
        is_prom  = (eff >= PROM_START);
        if (eff >= BA3_START) begin
            bank = 2'd3; bank_base = BA3_START;
        end else if (eff >= BA2_START) begin
            bank = 2'd2; bank_base = BA2_START;
        end else if (eff >= BA1_START) begin
            bank = 2'd1; bank_base = BA1_START;
        end else begin
            bank = 2'd0; bank_base = '0;
        end
        off            = eff - bank_base;
        new_entry.ba   = bank;
        new_entry.addr = off[24:1];
        new_entry.mask = lane_mask(off[0] ^ SWAB);
        new_entry.data = ioctl_dout;
    end

    assign sdram_push = ioctl_wr && !hdr_skip && !is_prom;
    assign prom_hit   = ioctl_wr && !hdr_skip && is_prom;

    logic        prom_we_q;
    logic [24:0] prom_addr_q;
    logic [7:0]  prom_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prom_we_q   <= 1'b0;
            prom_addr_q <= '0;
            prom_data_q <= '0;
        end else begin
            prom_we_q <= prom_hit;
            if (prom_hit) begin
                prom_addr_q <= eff - PROM_START;
                prom_data_q <= ioctl_dout;
            end
        end
    end

    assign prom_we   = prom_we_q;
    assign prom_addr = prom_addr_q;
    assign prom_data = prom_data_q;

    prog_state_e state_q, state_d;
    logic        issue;

    jtframe_prog_fifo #(
        .W  ($bits(prog_entry_t)),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (sdram_push),
        .pop   (issue),
        .din   (new_entry),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head = fifo_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = REQ;
            REQ:     if (prog_ack) state_d = prog_rdy ? IDLE : WAIT;
            WAIT:    if (prog_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issue   = 1'b0;
        prog_we = 1'b0;
        case (state_q)
            IDLE:    issue = !fifo_empty;
            REQ:     prog_we = 1'b1;
            default: ;
        endcase
    end

    logic [SDRAMW-1:0] prog_addr_q;
    logic [15:0]       prog_data_q;
    logic [1:0]        prog_mask_q, prog_ba_q;

    // Request fields are captured once at issue and held until the next issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_addr_q <= '0;
            prog_data_q <= '0;
            prog_mask_q <= '0;
            prog_ba_q   <= '0;
        end else if (issue) begin
            prog_addr_q <= SDRAMW'(head.addr);
            prog_data_q <= {head.data, head.data};
            prog_mask_q <= head.mask;
            prog_ba_q   <= head.ba;
        end
    end

    assign prog_addr = prog_addr_q;
    assign prog_data = prog_data_q;
    assign prog_mask = prog_mask_q;
    assign prog_ba   = prog_ba_q;

    logic dl_q, overflow_q, overflow_d, drop;

    assign drop = sdram_push && fifo_full && !issue;

    always_comb begin
        overflow_d = overflow_q | drop;
        if (downloading && !dl_q) overflow_d = drop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_q       <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            dl_q       <= downloading;
            overflow_q <= overflow_d;
        end
    end

    assign overflow   = overflow_q;
    assign dwnld_busy = downloading || !fifo_empty || (state_q != IDLE);

endmodule
